// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, drives the 1-cycle-latency instruction
// ROM and presents {valid, pc, instr} to decode. It handles decode stalls and
// downstream redirects, and presents NOP whenever no real fetch is in flight.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_dout,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] fetch_count
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            inflight_valid_q, inflight_valid_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic [XLEN-1:0] count_q, count_d;

  logic [XLEN-1:0] target_aligned;
  logic            accept;

  // Word-align the redirect target; low bits are dropped silently.
  always_comb begin
    target_aligned = redirect_target & ALIGN_MASK;
  end

  // ROM request: the redirect target is fetched in the same cycle it arrives.
  // Reads are suppressed during stall so the ROM holds its output word.
  always_comb begin
    imem_addr = redirect ? target_aligned : pc_q;
    imem_en   = rst & (redirect | ~id_stall);
  end

  // Decode takes the presented instruction only when it is real, decode is
  // not stalled and no redirect is flushing it.
  always_comb begin
    accept = rst & inflight_valid_q & ~id_stall & ~redirect;
  end

  // Next-state logic: redirect has priority over stall, and a stall holds
  // everything.
  always_comb begin
    pc_d             = pc_q;
    inflight_valid_d = inflight_valid_q;
    inflight_pc_d    = inflight_pc_q;
    count_d          = count_q;

    if (redirect) begin
      inflight_pc_d    = target_aligned;
      inflight_valid_d = 1'b1;
      pc_d             = target_aligned + PC_STEP;
    end else if (!id_stall) begin
      inflight_pc_d    = pc_q;
      inflight_valid_d = 1'b1;
      pc_d             = pc_q + PC_STEP;
    end

    if (accept) begin
      count_d = count_q + XLEN'(1);
    end
  end

  // State registers. The synchronous reset discards any in-flight fetch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q             <= RESET_PC;
      inflight_valid_q <= 1'b0;
      inflight_pc_q    <= '0;
      count_q          <= '0;
    end else begin
      pc_q             <= pc_d;
      inflight_valid_q <= inflight_valid_d;
      inflight_pc_q    <= inflight_pc_d;
      count_q          <= count_d;
    end
  end

  // Presentation to decode. The ROM word lines up with inflight_pc_q.
  always_comb begin
    if_valid    = inflight_valid_q;
    if_pc       = inflight_pc_q;
    if_instr    = inflight_valid_q ? imem_dout : NOP_INSTR;
    fetch_count = count_q;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural 1-cycle ROM and a
// scoreboard queue holding the expected presentation for the next cycle.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_dout;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] fetch_count;

  instruction_fetch #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_stall       (id_stall),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .imem_addr      (imem_addr),
    .imem_en        (imem_en),
    .imem_dout      (imem_dout),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  // 64-word ROM, 1-cycle read latency, holds dout while en=0.
  logic [31:0] rom [64];
  always @(posedge clk) begin
    if (imem_en) imem_dout <= rom[imem_addr[7:2]];
  end

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] count;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;        // expected presentation this cycle
  logic [31:0] model_pc;   // expected next sequential fetch PC
  int          n_asserts = 0;
  int          n_fail    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rom_at(input logic [31:0] a);
    return rom[a[7:2]];
  endfunction

  // Pop the scoreboard and compare against the DUT outputs.
  task automatic compare_out(input string tag);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      cur = sb.pop_front();
      check({tag, "_valid"}, {31'd0, if_valid}, {31'd0, cur.valid});
      check({tag, "_pc"},    if_pc,       cur.pc);
      check({tag, "_instr"}, if_instr,    cur.instr);
      check({tag, "_count"}, fetch_count, cur.count);
    end
  endtask

  // One cycle of reset, then check the reset presentation.
  task automatic do_reset(input string tag);
    exp_t e;
    rst = 1'b0; id_stall = 1'b0; redirect = 1'b0; redirect_target = '0;
    #1;
    check({tag, "_en_in_rst"}, {31'd0, imem_en}, 32'd0);
    sb.delete();
    e = '{valid: 1'b0, pc: 32'd0, instr: NOP_INSTR, count: 32'd0};
    sb.push_back(e);
    model_pc = RESET_PC;
    @(posedge clk); #1;
    compare_out(tag);
    rst = 1'b1;
  endtask

  // Drive one cycle of stimulus, push the expected result, then compare.
  task automatic step(input string tag, input logic stall, input logic redir,
                      input logic [31:0] tgt);
    exp_t        e;
    logic [31:0] a;
    rst = 1'b1; id_stall = stall; redirect = redir; redirect_target = tgt;
    #1;
    e = cur;
    if (cur.valid && !stall && !redir) e.count = cur.count + 32'd1;
    if (redir) begin
      a = {tgt[31:2], 2'b00};
      check({tag, "_addr"}, imem_addr, a);
      check({tag, "_en"}, {31'd0, imem_en}, 32'd1);
      e.valid = 1'b1; e.pc = a; e.instr = rom_at(a);
      model_pc = a + 32'd4;
    end else if (!stall) begin
      check({tag, "_addr"}, imem_addr, model_pc);
      check({tag, "_en"}, {31'd0, imem_en}, 32'd1);
      e.valid = 1'b1; e.pc = model_pc; e.instr = rom_at(model_pc);
      model_pc = model_pc + 32'd4;
    end else begin
      check({tag, "_en"}, {31'd0, imem_en}, 32'd0);
    end
    sb.push_back(e);
    @(posedge clk); #1;
    compare_out(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hA000_0000 | 32'(i);
    rom[0] = 32'h0000_0013;
    rom[1] = 32'h0080_00ef;
    rom[2] = 32'h00a0_0113;
    rom[3] = 32'h0140_0193;
    imem_dout = '0;
    cur = '0;
    rst = 1'b0; id_stall = 1'b0; redirect = 1'b0; redirect_target = '0;
    @(posedge clk); #1;

    // Free run from reset.
    do_reset("rst0");
    step("run_c1", 1'b0, 1'b0, 32'd0);
    check("run_c1_pc_lit", if_pc, 32'h0);
    check("run_c1_instr_lit", if_instr, 32'h0000_0013);
    step("run_c2", 1'b0, 1'b0, 32'd0);
    check("run_c2_instr_lit", if_instr, 32'h0080_00ef);
    step("run_c3", 1'b0, 1'b0, 32'd0);
    check("run_c3_pc_lit", if_pc, 32'h8);
    step("run_c4", 1'b0, 1'b0, 32'd0);
    check("run_count3_lit", fetch_count, 32'd3);

    // Redirect while pc=4 is presented; 8 must never appear.
    do_reset("rst1");
    step("rd_c1", 1'b0, 1'b0, 32'd0);
    step("rd_c2", 1'b0, 1'b0, 32'd0);
    step("rd_jump", 1'b0, 1'b1, 32'd12);
    check("rd_pc_lit", if_pc, 32'd12);
    check("rd_instr_lit", if_instr, 32'h0140_0193);
    step("rd_after", 1'b0, 1'b0, 32'd0);
    check("rd_not8", {31'd0, (if_pc == 32'd8)}, 32'd0);

    // Stall 3 cycles with pc=8 presented.
    do_reset("rst2");
    step("st_c1", 1'b0, 1'b0, 32'd0);
    step("st_c2", 1'b0, 1'b0, 32'd0);
    step("st_c3", 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step("st_hold", 1'b1, 1'b0, 32'd0);
      check("st_hold_pc_lit", if_pc, 32'd8);
      check("st_hold_instr_lit", if_instr, 32'h00a0_0113);
    end
    step("st_rel", 1'b0, 1'b0, 32'd0);
    check("st_rel_pc_lit", if_pc, 32'd12);

    // Stall and misaligned redirect together: redirect wins.
    step("sr_both", 1'b1, 1'b1, 32'h0000_0006);
    check("sr_pc_lit", if_pc, 32'd4);
    step("sr_next", 1'b0, 1'b0, 32'd0);
    check("sr_next_pc_lit", if_pc, 32'd8);

    // Back-to-back redirects, then PC wrap at the top of the address space.
    step("bb_1", 1'b0, 1'b1, 32'h0000_0020);
    step("bb_2", 1'b0, 1'b1, 32'hFFFF_FFFC);
    check("wrap_pc0_lit", if_pc, 32'hFFFF_FFFC);
    step("wrap_1", 1'b0, 1'b0, 32'd0);
    check("wrap_pc1_lit", if_pc, 32'h0000_0000);
    step("wrap_2", 1'b0, 1'b0, 32'd0);

    // Mid-stream reset with a valid instruction presented.
    do_reset("rst_mid");
    check("rst_mid_count_lit", fetch_count, 32'd0);
    step("rst_mid_c1", 1'b0, 1'b0, 32'd0);
    check("rst_mid_pc_lit", if_pc, RESET_PC);

    // Redirect in the first cycle after reset.
    do_reset("rst3");
    step("rd_first", 1'b0, 1'b1, 32'h0000_0010);
    step("rd_first_n", 1'b0, 1'b0, 32'd0);
    step("rd_first_n2", 1'b0, 1'b0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Instruction fetch stage at the head of base_pipeline, directly upstream of decode.
- Holds the PC and drives the synchronous instruction ROM, which has a 1-cycle read latency and holds dout while en=0.
- Tags each returned word with its PC and presents {valid, pc, instr} to decode.
- Honours decode back-pressure (stall) and jump/branch redirects; squashes wrong-path fetches by substituting NOP.

Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset.
- NOP_INSTR, 32'h00000013, word presented to decode when no valid fetch is in flight (addi x0,x0,0).

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- id_stall  in  1  decode cannot accept this cycle; hold the presented instruction.
- redirect  in  1  control-flow change resolved downstream this cycle.
- redirect_target  in  32  new PC; bits [1:0] are forced to 0.
- imem_addr  out  32  ROM byte address (combinational).
- imem_en  out  1  ROM read enable (combinational).
- imem_dout  in  32  ROM data, valid 1 cycle after an enabled request.
- if_valid  out  1  if_instr/if_pc hold a real fetched instruction.
- if_pc  out  32  PC of the presented instruction.
- if_instr  out  32  presented instruction; NOP_INSTR when if_valid=0.
- fetch_count  out  32  count of instructions accepted by decode.

Behaviour:
- State: pc_q (next fetch PC), inflight_valid_q, inflight_pc_q, count_q.
- Reset (rst=0 at posedge): pc_q=RESET_PC, inflight_valid_q=0, inflight_pc_q=0, count_q=0. Outputs in the cycle after reset: if_valid=0, if_pc=0, if_instr=NOP_INSTR, fetch_count=0.
- Reset mid-operation discards any in-flight fetch. imem_en=0 while rst=0.
- imem_addr = redirect ? {redirect_target[31:2],2'b00} : pc_q.
- imem_en = rst & (redirect | ~id_stall).
- if_valid = inflight_valid_q; if_pc = inflight_pc_q; if_instr = inflight_valid_q ? imem_dout : NOP_INSTR.
- Normal cycle (rst=1, redirect=0, id_stall=0):
  - inflight_pc_q<=pc_q, inflight_valid_q<=1, pc_q<=pc_q+4.
  - Sequential throughput is 1 instruction/cycle; reset-to-first-valid latency is 1 cycle.
- Stall (redirect=0, id_stall=1): all state holds and imem_en=0, so the ROM holds dout and if_* stay stable.
- Redirect (redirect=1, id_stall ignored):
  - The target is fetched in the same cycle.
  - inflight_pc_q<=target, inflight_valid_q<=1, pc_q<=target+4.
  - The instruction presented during the redirect cycle is discarded by decode's own flush. Any sequential fetch that would have followed is never issued; no bubble is added beyond that.
- Redirect has priority over stall when both are asserted.
- PC arithmetic is modulo 2^32: 32'hFFFFFFFC+4 = 0. No trap is raised.
- Misaligned target: bits [1:0] are silently cleared and no flag is raised.
- fetch_count increments by 1 on each posedge where rst=1, if_valid=1, id_stall=0 and redirect=0. It wraps at 2^32.
- Back-to-back redirects: each one overrides the previous and the last target wins.
- A redirect in the first cycle after reset is legal and is taken.

Test Plan:
- Reset then free-run with ROM {0:nop, 4:jal x1 8, 8:addi, 12:addi}, no stall/redirect -> cycle 1: if_valid=1, if_pc=0, if_instr=32'h00000013; cycle 2: if_pc=4, if_instr=32'h008000ef; cycle 3: if_pc=8; fetch_count=3 after the cycle-3 edge.
- redirect=1, target=12 in the cycle if_pc=4 is presented -> next cycle if_pc=12, if_instr=32'h01400193, if_valid=1; address 8 never appears on if_pc.
- Hold id_stall=1 for 3 cycles while if_pc=8 -> imem_en=0, and if_pc=8, if_instr=32'h00a00113 stay stable for all 3 cycles; fetch_count unchanged. After release: if_pc=12 next cycle.
- id_stall=1 and redirect=1 (target=32'h00000006) together -> imem_addr=4; next cycle if_pc=4, pc_q=8.
- Force pc_q=32'hFFFFFFFC and run 2 cycles -> if_pc sequence FFFFFFFC then 00000000.
- Drive rst=0 for 1 cycle mid-stream with a valid instruction presented -> next cycle if_valid=0, if_instr=NOP_INSTR, fetch_count=0; the cycle after that, if_pc=RESET_PC.
